uart_tick_scheduler: RTL and testbench

Baud-tick controller for the UART. It owns the baud-rate prescaler and shares its tick between the receiver and the transmitter. The receiver gets 16x oversample ticks. The transmitter gets a 1x bit tick whose phase is aligned to its start request. The block also accepts runtime divisor reconfiguration through a valid/ready handshake and applies it glitch-free at a tick boundary. It sits between the register/config interface and the RX/TX shift engines, replacing the free-running baud generator.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tick_scheduler_prescaler.sv | 54 +++++
 rtl/uart_tick_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tick_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and state encoding for the UART baud-tick
//                scheduler and its prescaler.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of the clock divisor (clock cycles per oversample tick).
    localparam int DIV_WIDTH   = 16;
    // RX oversample ticks per bit; must be a power of two.
    localparam int OVERSAMPLE  = 16;
    // Divisor after reset: 50 MHz / (19200 * 16) ~= 163.
    localparam int DEFAULT_DIV = 163;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // prescaler held at 0
        RUN    = 2'd1,  // prescaler counting
        RECONF = 2'd2   // counting, new divisor pending for the next wrap
    } state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tick_scheduler_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divisor counter. Counts 0..div_i-1 while enabled and flags
//                the wrap cycle. A clear forces the count back to 0 and
//                suppresses the wrap flag in that cycle.
//  Ports       : clk_i   - clock
//                rst_ni  - asynchronous active-low reset
//                en_i    - count enable
//                clr_i   - synchronous clear (wins over en_i)
//                div_i   - current divisor
//                wrap_o  - high in the cycle the counter wraps to 0
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int DIV_WIDTH = uart_pkg::DIV_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 wrap_o
);
    import uart_pkg::*;

    logic [DIV_WIDTH-1:0] presc_q;
    logic [DIV_WIDTH-1:0] presc_d;
    logic                 at_end;

    // ">=" rather than "==" so a count that is somehow beyond the end can
    // never run the full counter range before wrapping.
    assign at_end = (presc_q >= (div_i - DIV_WIDTH'(1)));
    assign wrap_o = en_i & ~clr_i & at_end;

    always_comb begin
        presc_d = presc_q;
        if (clr_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = at_end ? '0 : presc_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/uart_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tick_scheduler
//  Description : Baud-tick controller. Owns the shared prescaler, produces
//                16x oversample ticks for RX and a start-aligned 1x bit tick
//                for TX, and accepts runtime divisor changes over a
//                valid/ready handshake, applying them at a tick boundary.
//  Ports       : i_clock      - system clock (rising edge)
//                i_reset_n    - asynchronous active-low reset
//                i_cfg_valid  - new divisor offered
//                i_cfg_div    - requested divisor (cycles per oversample tick)
//                o_cfg_ready  - divisor can be accepted this cycle
//                i_rx_req     - receiver active (level)
//                o_rx_tick    - one-cycle oversample tick
//                i_tx_req     - transmitter active (level, rise = frame start)
//                o_tx_tick    - one-cycle bit tick
//                o_busy       - prescaler running
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tick_scheduler #(
    parameter int DIV_WIDTH   = uart_pkg::DIV_WIDTH,
    parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_cfg_valid,
    input  logic [DIV_WIDTH-1:0] i_cfg_div,
    output logic                 o_cfg_ready,
    input  logic                 i_rx_req,
    output logic                 o_rx_tick,
    input  logic                 i_tx_req,
    output logic                 o_tx_tick,
    output logic                 o_busy
);
    import uart_pkg::*;

    localparam int                   SUB_W    = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(2);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_pend_q, div_pend_d;
    logic                 cfg_ready_q, cfg_ready_d;
    logic [SUB_W-1:0]     sub_q, sub_d;
    logic                 tx_req_q;
    logic                 rx_tick_q, rx_tick_d;
    logic                 tx_tick_q, tx_tick_d;

    logic                 any_req;
    logic                 tx_rise;
    logic                 restart;
    logic                 cfg_xfer;
    logic [DIV_WIDTH-1:0] cfg_div_clamped;
    logic                 wrap;
    logic                 presc_en;
    logic                 presc_clr;
    logic                 load_direct;
    logic                 to_pend;
    logic                 apply_pend;

    assign any_req         = i_rx_req | i_tx_req;
    assign tx_rise         = i_tx_req & ~tx_req_q;
    // A TX start only realigns the shared prescaler when RX is not using it.
    assign restart         = tx_rise & ~i_rx_req;
    assign cfg_xfer        = i_cfg_valid & cfg_ready_q;
    assign cfg_div_clamped = (i_cfg_div < MIN_DIV) ? MIN_DIV : i_cfg_div;

    tick_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk_i  (i_clock),
        .rst_ni (i_reset_n),
        .en_i   (presc_en),
        .clr_i  (presc_clr),
        .div_i  (div_q),
        .wrap_o (wrap)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Request changes take priority over cfg transfers.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = RUN;
            end
            RUN: begin
                if (!any_req)     state_d = IDLE;
                else if (cfg_xfer) state_d = RECONF;
            end
            RECONF: begin
                if (!any_req)  state_d = IDLE;
                else if (wrap) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        presc_en    = 1'b0;
        presc_clr   = 1'b1;
        load_direct = 1'b0;
        to_pend     = 1'b0;
        apply_pend  = 1'b0;
        case (state_q)
            IDLE: begin
                // Prescaler is parked at 0, so a new divisor is safe at once.
                load_direct = cfg_xfer;
            end
            RUN: begin
                presc_en  = any_req;
                presc_clr = ~any_req | restart;
                // Dropping to IDLE in the same cycle makes a direct load safe.
                load_direct = cfg_xfer & ~any_req;
                to_pend     = cfg_xfer & any_req;
            end
            RECONF: begin
                presc_en   = any_req;
                presc_clr  = ~any_req | restart;
                apply_pend = wrap | ~any_req;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        div_d = div_q;
        if (load_direct) begin
            div_d = cfg_div_clamped;
        end else if (apply_pend) begin
            div_d = div_pend_q;
        end

        div_pend_d = to_pend ? cfg_div_clamped : div_pend_q;

        cfg_ready_d = cfg_ready_q;
        if (to_pend) begin
            cfg_ready_d = 1'b0;
        end else if (apply_pend) begin
            cfg_ready_d = 1'b1;
        end

        // A TX start (with or without RX) always restarts the bit count.
        sub_d = sub_q;
        if (!i_tx_req || tx_rise) begin
            sub_d = '0;
        end else if (wrap) begin
            sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
        end

        rx_tick_d = wrap & i_rx_req;
        tx_tick_d = wrap & i_tx_req & ~tx_rise & (sub_q == SUB_LAST);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div_q       <= DIV_WIDTH'(DEFAULT_DIV);
            div_pend_q  <= '0;
            cfg_ready_q <= 1'b1;
            sub_q       <= '0;
            tx_req_q    <= 1'b0;
            rx_tick_q   <= 1'b0;
            tx_tick_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            div_pend_q  <= div_pend_d;
            cfg_ready_q <= cfg_ready_d;
            sub_q       <= sub_d;
            tx_req_q    <= i_tx_req;
            rx_tick_q   <= rx_tick_d;
            tx_tick_q   <= tx_tick_d;
        end
    end

    assign o_cfg_ready = cfg_ready_q;
    assign o_rx_tick   = rx_tick_q;
    assign o_tx_tick   = tx_tick_q;
    assign o_busy      = (state_q != IDLE);

endmodule : uart_tick_scheduler
`default_nettype wire

// File: tb/tb_uart_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tick_scheduler
//  Description : Directed self-checking bench for uart_tick_scheduler with a
//                divisor of 4 after reset. Edge 0 of each scenario is the
//                first rising edge that samples the new request level.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tick_scheduler;

    localparam int DIV_WIDTH = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_valid;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic                 cfg_ready;
    logic                 rx_req;
    logic                 rx_tick;
    logic                 tx_req;
    logic                 tx_tick;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tick_scheduler #(
        .DIV_WIDTH   (DIV_WIDTH),
        .DEFAULT_DIV (4),
        .OVERSAMPLE  (16)
    ) u_dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_cfg_valid (cfg_valid),
        .i_cfg_div   (cfg_div),
        .o_cfg_ready (cfg_ready),
        .i_rx_req    (rx_req),
        .o_rx_tick   (rx_tick),
        .i_tx_req    (tx_req),
        .o_tx_tick   (tx_tick),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record rx_tick after each of n edges (bit e = edge e).
    task automatic capture_rx(input int n, output logic [63:0] rxv);
        rxv = '0;
        for (int e = 0; e < n; e++) begin
            step();
            rxv[e] = rx_tick;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] rxv;
        logic [63:0] readyv;
        logic        any_tx;
        logic        any_rx;
        logic        busy_all;
        int          first_tx;
        int          second_tx;
        int          rx_cnt;
        int          rx_off;
        int          tx_cnt;

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        rx_req    = 1'b0;
        tx_req    = 1'b0;
        repeat (3) step();

        // ---------------- reset values ----------------
        check("rst_rx_tick", rx_tick, 0);
        check("rst_tx_tick", tx_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        step();

        // ---------------- RX only, div 4 ----------------
        rx_req   = 1'b1;
        rxv      = '0;
        any_tx   = 1'b0;
        busy_all = 1'b1;
        for (int e = 0; e < 16; e++) begin
            step();
            rxv[e]   = rx_tick;
            any_tx   = any_tx | tx_tick;
            busy_all = busy_all & busy;
        end
        check("rx_only_ticks", rxv, 64'h1110);
        check("rx_only_no_tx", any_tx, 0);
        check("rx_only_busy", busy_all, 1);
        rx_req = 1'b0;
        step();
        check("rx_drop_idle", busy, 0);

        // ---------------- TX only, div 4 ----------------
        tx_req    = 1'b1;
        first_tx  = -1;
        second_tx = -1;
        any_rx    = 1'b0;
        busy_all  = 1'b1;
        for (int e = 0; e < 140; e++) begin
            step();
            if (tx_tick) begin
                if (first_tx < 0)       first_tx  = e;
                else if (second_tx < 0) second_tx = e;
            end
            any_rx   = any_rx | rx_tick;
            busy_all = busy_all & busy;
        end
        check("tx_first_tick", 64'(first_tx), 64);
        check("tx_second_tick", 64'(second_tx), 128);
        check("tx_only_no_rx", any_rx, 0);
        check("tx_only_busy", busy_all, 1);
        tx_req = 1'b0;
        step();
        check("tx_drop_idle", busy, 0);

        // ---------------- reconfigure to 6 while RX runs ----------------
        rx_req = 1'b1;
        rxv    = '0;
        readyv = '0;
        for (int e = 0; e < 26; e++) begin
            step();
            rxv[e]    = rx_tick;
            readyv[e] = cfg_ready;
            if (e == 9) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd6;
            end
            if (e == 10) begin
                cfg_valid = 1'b0;
                cfg_div   = '0;
            end
        end
        check("reconf_rx_ticks", rxv, 64'h0104_1110);
        check("reconf_ready", readyv, 64'h03FF_F3FF);
        rx_req = 1'b0;
        step();

        // ---------------- clamp: divisor 0 in IDLE ----------------
        cfg_valid = 1'b1;
        cfg_div   = 16'd0;
        step();
        cfg_valid = 1'b0;
        check("idle_cfg_ready", cfg_ready, 1);
        rx_req = 1'b1;
        capture_rx(12, rxv);
        check("clamp_rx_ticks", rxv, 64'h0554);
        rx_req = 1'b0;
        step();

        // ---------------- TX start while RX active, div 4 ----------------
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        step();
        cfg_valid = 1'b0;
        cfg_div   = '0;
        rx_req    = 1'b1;
        rx_cnt    = 0;
        rx_off    = 0;
        tx_cnt    = 0;
        first_tx  = -1;
        for (int e = 0; e < 72; e++) begin
            step();
            if (rx_tick) begin
                rx_cnt++;
                if ((e % 4) != 0) rx_off++;
            end
            if (tx_tick) begin
                tx_cnt++;
                if (first_tx < 0) first_tx = e;
            end
            if (e == 5) tx_req = 1'b1;
        end
        check("shared_rx_count", 64'(rx_cnt), 17);
        check("shared_rx_phase", 64'(rx_off), 0);
        check("shared_tx_first", 64'(first_tx), 68);
        check("shared_tx_count", 64'(tx_cnt), 1);
        rx_req = 1'b0;
        tx_req = 1'b0;
        step();

        // ---------------- async reset during RECONF ----------------
        rx_req = 1'b1;
        for (int e = 0; e < 7; e++) begin
            step();
            if (e == 4) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd9;
            end
            if (e == 5) begin
                cfg_valid = 1'b0;
                cfg_div   = '0;
            end
        end
        check("pre_rst_ready", cfg_ready, 0);
        check("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rx_tick", rx_tick, 0);
        check("async_rst_tx_tick", tx_tick, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", cfg_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        capture_rx(10, rxv);
        check("post_rst_rx_ticks", rxv, 64'h0110);
        rx_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tick_scheduler
`default_nettype wire
